// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration for the LSM regression datapath:
// word widths, accumulator/counter sizes, sum indices and the
// normal-equation accumulator state type.
package fpga_cfg_pkg;

  localparam int FP_WIDTH      = 32;
  localparam int FP_QFRAC      = 16;
  localparam int LSM_ACC_WIDTH = 48;
  localparam int LSM_CNT_WIDTH = 16;

  // Running sums kept by the accumulator, in storage order.
  localparam int LSM_NSUM    = 7;
  localparam int LSM_SUM_S   = 0;
  localparam int LSM_SUM_S2  = 1;
  localparam int LSM_SUM_S3  = 2;
  localparam int LSM_SUM_S4  = 3;
  localparam int LSM_SUM_Y   = 4;
  localparam int LSM_SUM_YS  = 5;
  localparam int LSM_SUM_YS2 = 6;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    EMIT  = 2'd2
  } lsm_acc_state_t;

endpackage

// File: rtl/lsm_sat_mul.sv
// Combinational signed Q-format multiply: full-width product, arithmetic
// shift by the fraction bits, then saturation back to the word width.
// The caller registers the result.
module lsm_sat_mul
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int QFRAC = FP_QFRAC
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] p_o
);

  localparam logic signed [2*WIDTH-1:0] P_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] P_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [2*WIDTH-1:0] shr_s;

  // Sign-extended product, rescale, clamp to the representable range.
  always_comb begin
    prod_s = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
    shr_s  = prod_s >>> QFRAC;
    if (shr_s > P_MAX) begin
      p_o = P_MAX[WIDTH-1:0];
    end else if (shr_s < P_MIN) begin
      p_o = P_MIN[WIDTH-1:0];
    end else begin
      p_o = shr_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/lsm_normal_eq_accum.sv
// Normal-equation accumulator for the 3x3 Longstaff-Schwartz regression.
// Streams (S, y) samples, builds sums over phi = [1, S, S^2] through a
// two-stage multiply pipeline and emits A_flat/B_flat with a one-cycle
// out_valid pulse four cycles after the last sample.
// Optional build macro LSM_ITM_FILTER_EN: only samples with y_in > 0 are
// accumulated and counted; the handshake is unchanged.
module lsm_normal_eq_accum
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH     = FP_WIDTH,
  parameter int QFRAC     = FP_QFRAC,
  parameter int ACC_WIDTH = LSM_ACC_WIDTH,
  parameter int CNT_WIDTH = LSM_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic             sample_last,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] A_flat [0:8],
  output logic [WIDTH-1:0] B_flat [0:2],
  output logic             busy
);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Clamp an accumulator value to the output word range.
  function automatic logic [WIDTH-1:0] sat_acc(input logic [ACC_WIDTH-1:0] v);
    logic signed [ACC_WIDTH-1:0] sv;
    sv = $signed(v);
    if (sv > ACC_MAX)      return OUT_MAX;
    else if (sv < ACC_MIN) return OUT_MIN;
    else                   return v[WIDTH-1:0];
  endfunction

  // Add a sign-extended word to an accumulator, sticking at the rails.
  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0]     b);
    logic [ACC_WIDTH:0] sum;
    sum = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH-WIDTH+1){b[WIDTH-1]}}, b};
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      return sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      return sum[ACC_WIDTH-1:0];
    end
  endfunction

  logic             accept_s, itm_s, take_s, clear_s;
  logic [WIDTH-1:0] s2_s, ys_s, s3_s, s4_s, ys2_s;

  logic             p1_v_q;
  logic [WIDTH-1:0] p1_s_q, p1_y_q, p1_s2_q, p1_ys_q;
  logic             p2_v_q;
  logic [WIDTH-1:0] p2_term_q [LSM_NSUM];
  logic [ACC_WIDTH-1:0] acc_q [LSM_NSUM];

  lsm_acc_state_t   state_q;
  logic             phase_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [WIDTH-1:0] a_q [0:8];
  logic [WIDTH-1:0] b_q [0:2];

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign A_flat    = a_q;
  assign B_flat    = b_q;

  // Handshake qualification and in-the-money selection.
  always_comb begin
    accept_s = sample_valid & in_ready_q;
`ifdef LSM_ITM_FILTER_EN
    itm_s    = ($signed(y_in) > $signed({WIDTH{1'b0}}));
`else
    itm_s    = 1'b1;
`endif
    take_s   = accept_s & itm_s;
    clear_s  = (state_q == EMIT) && phase_q;
  end

  // Stage-1 products from the raw sample, stage-2 products from stage-1 registers.
  lsm_sat_mul #(.WIDTH(WIDTH), .QFRAC(QFRAC)) u_mul_s2  (.a_i(s_in),    .b_i(s_in),    .p_o(s2_s));
  lsm_sat_mul #(.WIDTH(WIDTH), .QFRAC(QFRAC)) u_mul_ys  (.a_i(y_in),    .b_i(s_in),    .p_o(ys_s));
  lsm_sat_mul #(.WIDTH(WIDTH), .QFRAC(QFRAC)) u_mul_s3  (.a_i(p1_s2_q), .b_i(p1_s_q),  .p_o(s3_s));
  lsm_sat_mul #(.WIDTH(WIDTH), .QFRAC(QFRAC)) u_mul_s4  (.a_i(p1_s2_q), .b_i(p1_s2_q), .p_o(s4_s));
  lsm_sat_mul #(.WIDTH(WIDTH), .QFRAC(QFRAC)) u_mul_ys2 (.a_i(p1_ys_q), .b_i(p1_s_q),  .p_o(ys2_s));

  // Two-stage product pipeline; the valid bit tracks only samples to be summed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v_q  <= 1'b0;
      p1_s_q  <= '0;
      p1_y_q  <= '0;
      p1_s2_q <= '0;
      p1_ys_q <= '0;
      p2_v_q  <= 1'b0;
      for (int i = 0; i < LSM_NSUM; i++) p2_term_q[i] <= '0;
    end else begin
      p1_v_q  <= take_s;
      p1_s_q  <= s_in;
      p1_y_q  <= y_in;
      p1_s2_q <= s2_s;
      p1_ys_q <= ys_s;
      p2_v_q  <= p1_v_q;
      p2_term_q[LSM_SUM_S]   <= p1_s_q;
      p2_term_q[LSM_SUM_S2]  <= p1_s2_q;
      p2_term_q[LSM_SUM_S3]  <= s3_s;
      p2_term_q[LSM_SUM_S4]  <= s4_s;
      p2_term_q[LSM_SUM_Y]   <= p1_y_q;
      p2_term_q[LSM_SUM_YS]  <= p1_ys_q;
      p2_term_q[LSM_SUM_YS2] <= ys2_s;
    end
  end

  // Saturating running sums, cleared once the batch result has been emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LSM_NSUM; i++) acc_q[i] <= '0;
    end else if (clear_s) begin
      for (int i = 0; i < LSM_NSUM; i++) acc_q[i] <= '0;
    end else if (p2_v_q) begin
      for (int i = 0; i < LSM_NSUM; i++) acc_q[i] <= sat_add(acc_q[i], p2_term_q[i]);
    end
  end

  // Batch control: accept, drain the pipeline, register outputs, pulse valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < 9; i++) a_q[i] <= '0;
      for (int i = 0; i < 3; i++) b_q[i] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (accept_s) begin
            busy_q <= 1'b1;
            if (take_s && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_q <= cnt_q + CNT_ONE;
            if (sample_last) begin
              state_q    <= DRAIN;
              phase_q    <= 1'b0;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Two cycles let the last sample reach the accumulators.
          if (phase_q) begin
            state_q <= EMIT;
            phase_q <= 1'b0;
          end else begin
            phase_q <= 1'b1;
          end
        end
        EMIT: begin
          if (!phase_q) begin
            a_q[0] <= sat_acc({{(ACC_WIDTH-CNT_WIDTH){1'b0}}, cnt_q} << QFRAC);
            a_q[1] <= sat_acc(acc_q[LSM_SUM_S]);
            a_q[2] <= sat_acc(acc_q[LSM_SUM_S2]);
            a_q[3] <= sat_acc(acc_q[LSM_SUM_S]);
            a_q[4] <= sat_acc(acc_q[LSM_SUM_S2]);
            a_q[5] <= sat_acc(acc_q[LSM_SUM_S3]);
            a_q[6] <= sat_acc(acc_q[LSM_SUM_S2]);
            a_q[7] <= sat_acc(acc_q[LSM_SUM_S3]);
            a_q[8] <= sat_acc(acc_q[LSM_SUM_S4]);
            b_q[0] <= sat_acc(acc_q[LSM_SUM_Y]);
            b_q[1] <= sat_acc(acc_q[LSM_SUM_YS]);
            b_q[2] <= sat_acc(acc_q[LSM_SUM_YS2]);
            out_valid_q <= 1'b1;
            phase_q     <= 1'b1;
          end else begin
            state_q    <= ACCUM;
            phase_q    <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= ACCUM;
          phase_q    <= 1'b0;
          cnt_q      <= '0;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsm_normal_eq_accum.sv
// Self-checking bench for lsm_normal_eq_accum: hand-computed vector table,
// multi-cycle corner sequences and randomized batches against a plain
// arithmetic model of the normal-equation sums.
module tb_lsm_normal_eq_accum;

  localparam longint MAX32 = 64'sd2147483647;
  localparam longint MIN32 = -64'sd2147483648;
  localparam longint MAX48 = 64'sd140737488355327;
  localparam longint MIN48 = -64'sd140737488355328;

  logic        clk = 1'b0;
  logic        rst_n, sample_valid, sample_last;
  logic [31:0] s_in, y_in;
  logic        in_ready, out_valid, busy;
  logic [31:0] A_flat [0:8];
  logic [31:0] B_flat [0:2];

  int checks = 0;
  int failures = 0;
  int q_s[$];
  int q_y[$];
  logic [31:0] exp_a [9];
  logic [31:0] exp_b [3];

  typedef struct {
    logic [31:0] s, y;
    logic [31:0] a00, a01, a02, a12, a22, b0, b1, b2;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  lsm_normal_eq_accum dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_last(sample_last),
    .s_in(s_in), .y_in(y_in), .in_ready(in_ready), .out_valid(out_valid),
    .A_flat(A_flat), .B_flat(B_flat), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  task automatic compare_outputs(input string tag);
    for (int i = 0; i < 9; i++) chk($sformatf("%s_A%0d", tag, i), A_flat[i], exp_a[i]);
    for (int i = 0; i < 3; i++) chk($sformatf("%s_B%0d", tag, i), B_flat[i], exp_b[i]);
  endtask

  function automatic longint sat32(input longint v);
    if (v > MAX32) return MAX32;
    if (v < MIN32) return MIN32;
    return v;
  endfunction

  function automatic longint sat48(input longint v);
    if (v > MAX48) return MAX48;
    if (v < MIN48) return MIN48;
    return v;
  endfunction

  function automatic longint mulq(input longint a, input longint b);
    return sat32((a * b) >>> 16);
  endfunction

  // Reference: normal equations over phi = [1, S, S^2] for the queued batch.
  task automatic model_expect();
    longint n;
    longint sum_s, sum_s2, sum_s3, sum_s4, sum_y, sum_ys, sum_ys2;
    longint s, y, s2, ys;
    n = 0; sum_s = 0; sum_s2 = 0; sum_s3 = 0; sum_s4 = 0; sum_y = 0; sum_ys = 0; sum_ys2 = 0;
    for (int i = 0; i < q_s.size(); i++) begin
      s = longint'(q_s[i]);
      y = longint'(q_y[i]);
`ifdef LSM_ITM_FILTER_EN
      if (y <= 0) continue;
`endif
      if (n < 65535) n++;
      s2 = mulq(s, s);
      ys = mulq(y, s);
      sum_s   = sat48(sum_s + s);
      sum_s2  = sat48(sum_s2 + s2);
      sum_s3  = sat48(sum_s3 + mulq(s2, s));
      sum_s4  = sat48(sum_s4 + mulq(s2, s2));
      sum_y   = sat48(sum_y + y);
      sum_ys  = sat48(sum_ys + ys);
      sum_ys2 = sat48(sum_ys2 + mulq(ys, s));
    end
    exp_a[0] = 32'(sat32(n * 65536));
    exp_a[1] = 32'(sat32(sum_s));
    exp_a[2] = 32'(sat32(sum_s2));
    exp_a[3] = exp_a[1];
    exp_a[4] = exp_a[2];
    exp_a[5] = 32'(sat32(sum_s3));
    exp_a[6] = exp_a[2];
    exp_a[7] = exp_a[5];
    exp_a[8] = 32'(sat32(sum_s4));
    exp_b[0] = 32'(sat32(sum_y));
    exp_b[1] = 32'(sat32(sum_ys));
    exp_b[2] = 32'(sat32(sum_ys2));
  endtask

  task automatic set_exp_const(input logic [31:0] a00, a01, a02, a12, a22, b0, b1, b2);
    exp_a = '{a00, a01, a02, a01, a02, a12, a02, a12, a22};
    exp_b = '{b0, b1, b2};
  endtask

  // Feed the queued batch, then check the drain/emit timing and outputs.
  task automatic run_batch(input string tag, input bit noise, input bit gaps);
    int i;
    i = 0;
    while (i < q_s.size()) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        sample_valid = 1'b0;
        sample_last  = 1'b0;
        tick();
        continue;
      end
      sample_valid = 1'b1;
      s_in = q_s[i];
      y_in = q_y[i];
      sample_last = (i == q_s.size() - 1);
      chk({tag, "_in_ready_accum"}, {31'd0, in_ready}, 32'd1);
      tick();
      i++;
    end
    for (int k = 1; k <= 4; k++) begin
      if (noise) begin
        sample_valid = 1'b1;
        s_in = 32'h0005_0000;
        y_in = 32'h0001_0000;
        sample_last = 1'($urandom_range(0, 1));
      end else begin
        sample_valid = 1'b0;
        sample_last  = 1'b0;
      end
      chk($sformatf("%s_in_ready_T%0d", tag, k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("%s_busy_T%0d", tag, k), {31'd0, busy}, 32'd1);
      if (k < 4) begin
        chk($sformatf("%s_out_valid_T%0d", tag, k), {31'd0, out_valid}, 32'd0);
      end else begin
        chk({tag, "_out_valid_T4"}, {31'd0, out_valid}, 32'd1);
        compare_outputs(tag);
      end
      tick();
    end
    sample_valid = 1'b0;
    sample_last  = 1'b0;
    chk({tag, "_in_ready_T5"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid_T5"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy_T5"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hold_A0"}, A_flat[0], exp_a[0]);
    chk({tag, "_hold_B2"}, B_flat[2], exp_b[2]);
  endtask

  initial begin
    // {S, y} -> {A00, A01, A02, A12, A22, B0, B1, B2}
    vecs[0] = '{32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 32'h0004_0000,
                32'h0008_0000, 32'h0010_0000, 32'h0001_0000, 32'h0002_0000, 32'h0004_0000};
    vecs[1] = '{32'hFFFF_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000,
                32'hFFFF_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000};
    vecs[2] = '{32'h00C8_0000, 32'h0001_0000, 32'h0001_0000, 32'h00C8_0000, 32'h7FFF_FFFF,
                32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0001_0000, 32'h00C8_0000, 32'h7FFF_FFFF};
    vecs[3] = '{32'h0000_8000, 32'h0003_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_4000,
                32'h0000_2000, 32'h0000_1000, 32'h0003_0000, 32'h0001_8000, 32'h0000_C000};

    rst_n = 1'b0;
    sample_valid = 1'b0;
    sample_last = 1'b0;
    s_in = '0;
    y_in = '0;
    tick();
    tick();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    set_exp_const('0, '0, '0, '0, '0, '0, '0, '0);
    compare_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single-sample batches from the table.
    for (int v = 0; v < 4; v++) begin
      q_s = {int'(vecs[v].s)};
      q_y = {int'(vecs[v].y)};
      set_exp_const(vecs[v].a00, vecs[v].a01, vecs[v].a02, vecs[v].a12, vecs[v].a22,
                    vecs[v].b0, vecs[v].b1, vecs[v].b2);
      run_batch($sformatf("vec%0d", v), 1'b0, 1'b0);
    end

    // Three identical samples.
    q_s = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
    q_y = {32'h0002_0000, 32'h0002_0000, 32'h0002_0000};
    set_exp_const(32'h0003_0000, 32'h0003_0000, 32'h0003_0000, 32'h0003_0000, 32'h0003_0000,
                  32'h0006_0000, 32'h0006_0000, 32'h0006_0000);
    run_batch("three", 1'b0, 1'b0);

    // Samples offered while draining must be dropped.
    q_s = {32'h0002_0000};
    q_y = {32'h0001_0000};
    model_expect();
    run_batch("noise", 1'b1, 1'b0);
    q_s = {32'h0001_0000};
    q_y = {32'h0001_0000};
    set_exp_const(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                  32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    run_batch("after_noise", 1'b0, 1'b0);

    // Reset in the middle of a batch discards the partial sums.
    for (int i = 0; i < 2; i++) begin
      sample_valid = 1'b1;
      sample_last  = 1'b0;
      s_in = 32'h0003_0000;
      y_in = 32'h0001_0000;
      tick();
    end
    sample_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_A0", A_flat[0], 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_out_valid", {31'd0, out_valid}, 32'd0);
    q_s = {32'h0001_0000};
    q_y = {32'h0001_0000};
    set_exp_const(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                  32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    run_batch("postrst", 1'b0, 1'b0);

    // Mixed-sign payoffs and an all-non-positive batch.
    q_s = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
    q_y = {32'h0001_0000, 32'h0000_0000, 32'hFFFF_0000};
    model_expect();
    run_batch("itm_mix", 1'b0, 1'b0);
    q_s = {32'h0004_0000};
    q_y = {32'hFFFF_0000};
    model_expect();
    run_batch("itm_none", 1'b0, 1'b0);

    // Randomized batches with gaps and ignored drain-time traffic.
    for (int b = 0; b < 12; b++) begin
      int len;
      len = int'($urandom_range(1, 6));
      q_s.delete();
      q_y.delete();
      for (int i = 0; i < len; i++) begin
        if (b % 3 == 2) q_s.push_back(int'($urandom_range(0, 32'h0200_0000)) - 32'sh0100_0000);
        else            q_s.push_back(int'($urandom_range(0, 32'h000F_FFFF)) - 32'sh0008_0000);
        q_y.push_back(int'($urandom_range(0, 32'h001F_FFFF)) - 32'sh0010_0000);
      end
      model_expect();
      run_batch($sformatf("rand%0d", b), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
